// File: rtl/twos_complement_serial_unit.sv
// Serial 2's-complement converter. It handles DIGIT bits per clock, LSB first, using copy-to-first-1-then-invert.
// It supports four modes: negate, abs, sign-magnitude->2C and 2C->sign-magnitude, with valid/ready on both sides.
module twos_complement_serial_unit #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             busy
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  generate
    if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
      $error("twos_complement_serial_unit: WIDTH must be >= 2 and divisible by DIGIT");
    end
  endgenerate

  state_t             state_reg;
  logic [CNT_W-1:0]   cnt_reg;
  logic               seen_one_reg;
  logic               neg_reg;
  logic               sm_out_reg;
  logic               sign_reg;
  logic               ovf_pend_reg;
  logic [WIDTH-1:0]   op_reg;
  logic [WIDTH-1:0]   res_reg;
  logic               in_ready_reg;
  logic               out_valid_reg;
  logic [WIDTH-1:0]   out_data_reg;
  logic               out_ovf_reg;
  logic               busy_reg;

  // Operand decode at capture time.
  logic               cap_neg;
  logic [WIDTH-1:0]   cap_op;
  logic               cap_ovf;

  always_comb begin
    cap_neg = (in_mode == 2'd0) ? 1'b1 : in_data[WIDTH-1];
    cap_op  = (in_mode == 2'd2) ? {1'b0, in_data[WIDTH-2:0]} : in_data;
    // Mode 2 strips the sign, so its operand can never equal MIN.
    cap_ovf = (in_mode != 2'd2) && cap_neg && (in_data == MIN_VAL);
  end

  // One digit of the serial algorithm: seen_one ripples across the DIGIT bits.
  logic [DIGIT:0]     seen_chain;
  logic [DIGIT-1:0]   digit_r;
  logic [WIDTH-1:0]   res_next;
  logic [WIDTH-1:0]   final_data;

  assign seen_chain[0] = seen_one_reg;

  generate
    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_digit
      assign digit_r[gi]       = (neg_reg & seen_chain[gi]) ? ~op_reg[gi] : op_reg[gi];
      assign seen_chain[gi+1]  = seen_chain[gi] | op_reg[gi];
    end
    if (DIGIT == WIDTH) begin : g_res_full
      assign res_next = digit_r;
    end else begin : g_res_shift
      assign res_next = {digit_r, res_reg[WIDTH-1:DIGIT]};
    end
  endgenerate

  assign final_data = sm_out_reg ? {sign_reg, res_next[WIDTH-2:0]} : res_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      seen_one_reg  <= 1'b0;
      neg_reg       <= 1'b0;
      sm_out_reg    <= 1'b0;
      sign_reg      <= 1'b0;
      ovf_pend_reg  <= 1'b0;
      op_reg        <= '0;
      res_reg       <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_ovf_reg   <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            op_reg       <= cap_op;
            neg_reg      <= cap_neg;
            sm_out_reg   <= (in_mode == 2'd3);
            sign_reg     <= in_data[WIDTH-1];
            ovf_pend_reg <= cap_ovf;
            cnt_reg      <= '0;
            seen_one_reg <= 1'b0;
            res_reg      <= '0;
            state_reg    <= RUN;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        RUN: begin
          op_reg       <= op_reg >> DIGIT;
          res_reg      <= res_next;
          seen_one_reg <= seen_chain[DIGIT];
          cnt_reg      <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            state_reg     <= DONE;
            out_valid_reg <= 1'b1;
            out_data_reg  <= final_data;
            out_ovf_reg   <= ovf_pend_reg;
          end
        end
        DONE: begin
          // Result is held until the consumer takes it; no accept on this edge.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_ovf   = out_ovf_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_twos_complement_serial_unit.sv
// Bench for twos_complement_serial_unit: an 8-bit/1-digit instance and a 16-bit/2-digit instance,
// checked against an arithmetic reference model.
module tb_twos_complement_serial_unit;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf, a_busy;
  logic [7:0]  a_in_data, a_out_data;
  logic [1:0]  a_in_mode;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf, b_busy;
  logic [15:0] b_in_data, b_out_data;
  logic [1:0]  b_in_mode;

  int vectors = 0;
  int miscompares = 0;

  twos_complement_serial_unit #(.WIDTH(8), .DIGIT(1)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .out_ovf(a_out_ovf), .busy(a_busy)
  );

  twos_complement_serial_unit #(.WIDTH(16), .DIGIT(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .out_ovf(b_out_ovf), .busy(b_busy)
  );

  // Reference: plain modular arithmetic on the operand value.
  function automatic void model(input logic [15:0] d, input logic [1:0] m, input int w,
                                output logic [15:0] r, output logic o);
    int unsigned mask, minv, x, mag;
    mask = (32'd1 << w) - 32'd1;
    minv = 32'd1 << (w - 1);
    x    = 32'(d) & mask;
    o    = 1'b0;
    r    = 16'(x);
    case (m)
      2'd0: begin
        r = 16'((32'd0 - x) & mask);
        o = (x == minv);
      end
      2'd1: if ((x & minv) != 0) begin
        r = 16'((32'd0 - x) & mask);
        o = (x == minv);
      end
      2'd2: if ((x & minv) != 0) begin
        mag = x & (minv - 32'd1);
        r   = 16'((32'd0 - mag) & mask);
      end
      default: if ((x & minv) != 0) begin
        mag = (32'd0 - x) & mask;
        r   = 16'(minv | (mag & (minv - 32'd1)));
        o   = (x == minv);
      end
    endcase
  endfunction

  // Full transaction on the 8-bit unit; called and returns on a falling edge.
  task automatic run_a(input logic [7:0] d, input logic [1:0] m,
                       output logic [7:0] r, output logic o, output int lat);
    int k;
    lat = -1; r = '0; o = 1'b0; k = 0;
    while (!a_in_ready && k < 50) begin @(negedge clk); k++; end
    a_in_valid = 1'b1; a_in_data = d; a_in_mode = m;
    @(posedge clk);
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = 8'($urandom); a_in_mode = 2'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_out_valid) begin lat = i; break; end
    end
    if (lat < 0) return;
    r = a_out_data; o = a_out_ovf;
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
  endtask

  task automatic run_b(input logic [15:0] d, input logic [1:0] m,
                       output logic [15:0] r, output logic o, output int lat);
    int k;
    lat = -1; r = '0; o = 1'b0; k = 0;
    while (!b_in_ready && k < 50) begin @(negedge clk); k++; end
    b_in_valid = 1'b1; b_in_data = d; b_in_mode = m;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0; b_in_data = 16'($urandom); b_in_mode = 2'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (b_out_valid) begin lat = i; break; end
    end
    if (lat < 0) return;
    r = b_out_data; o = b_out_ovf;
    b_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    b_out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({a_out_valid, a_busy, a_in_ready, a_out_ovf, a_out_data} !== {3'b001, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_a: got valid=%b busy=%b ready=%b ovf=%b data=%h, want 0 0 1 0 00",
               a_out_valid, a_busy, a_in_ready, a_out_ovf, a_out_data);
    end
    vectors++;
    if ({b_out_valid, b_busy, b_in_ready, b_out_ovf, b_out_data} !== {3'b001, 1'b0, 16'h0000}) begin
      miscompares++;
      $display("FAIL reset_b: got valid=%b busy=%b ready=%b ovf=%b data=%h, want 0 0 1 0 0000",
               b_out_valid, b_busy, b_in_ready, b_out_ovf, b_out_data);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed();
    logic [7:0] din  [11] = '{8'h0B, 8'h00, 8'hFF, 8'h80, 8'hD5, 8'h2B, 8'h85, 8'h80, 8'hFB, 8'h05, 8'h80};
    logic [1:0] mode [11] = '{2'd0,  2'd0,  2'd0,  2'd0,  2'd1,  2'd1,  2'd2,  2'd2,  2'd3,  2'd3,  2'd3};
    logic [7:0] exp  [11] = '{8'hF5, 8'h00, 8'h01, 8'h80, 8'h2B, 8'h2B, 8'hFB, 8'h00, 8'h85, 8'h05, 8'h80};
    logic       eovf [11] = '{1'b0,  1'b0,  1'b0,  1'b1,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b0,  1'b1};
    logic [7:0] r;
    logic       o;
    int         lat;
    for (int i = 0; i < 11; i++) begin
      run_a(din[i], mode[i], r, o, lat);
      vectors++;
      if (lat !== 8) begin
        miscompares++;
        $display("FAIL latency_a[%0d]: got %0d edges, want 8", i, lat);
      end
      vectors++;
      if ({r, o} !== {exp[i], eovf[i]}) begin
        miscompares++;
        $display("FAIL directed[%0d] m%0d %h: got %h ovf=%b, want %h ovf=%b",
                 i, mode[i], din[i], r, o, exp[i], eovf[i]);
      end
    end
  endtask

  task automatic test_hold();
    logic [7:0] r;
    logic       o;
    int         lat;
    bit         seen;
    a_in_valid = 1'b1; a_in_data = 8'h3C; a_in_mode = 2'd0;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); @(negedge clk);
      seen = a_out_valid;
    end
    vectors++;
    if (!seen || a_out_data !== 8'hC4) begin
      miscompares++;
      $display("FAIL hold_result: got valid=%b data=%h, want 1 C4", seen, a_out_data);
    end
    for (int c = 0; c < 5; c++) begin
      a_in_valid = 1'b1; a_in_data = 8'($urandom); a_in_mode = 2'($urandom);
      @(posedge clk); @(negedge clk);
      vectors++;
      if ({a_out_valid, a_out_data, a_out_ovf, a_in_ready, a_busy} !== {1'b1, 8'hC4, 1'b0, 1'b0, 1'b1}) begin
        miscompares++;
        $display("FAIL hold_cycle%0d: got valid=%b data=%h ovf=%b ready=%b busy=%b, want 1 C4 0 0 1",
                 c, a_out_valid, a_out_data, a_out_ovf, a_in_ready, a_busy);
      end
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    a_out_ready = 1'b0;
    vectors++;
    if ({a_out_valid, a_in_ready, a_busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL hold_release: got valid=%b ready=%b busy=%b, want 0 1 0",
               a_out_valid, a_in_ready, a_busy);
    end
    run_a(8'h12, 2'd0, r, o, lat);
    vectors++;
    if ({r, o} !== {8'hEE, 1'b0} || lat !== 8) begin
      miscompares++;
      $display("FAIL hold_next: got %h ovf=%b lat=%0d, want EE ovf=0 lat=8", r, o, lat);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] r;
    logic       o;
    int         lat;
    bit         spurious;
    a_in_valid = 1'b1; a_in_data = 8'h5A; a_in_mode = 2'd0;
    @(posedge clk); @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_out_valid, a_busy, a_in_ready, a_out_ovf, a_out_data} !== {3'b001, 1'b0, 8'h00}) begin
      miscompares++;
      $display("FAIL reset_mid: got valid=%b busy=%b ready=%b ovf=%b data=%h, want 0 0 1 0 00",
               a_out_valid, a_busy, a_in_ready, a_out_ovf, a_out_data);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    spurious = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (a_out_valid || a_busy) spurious = 1'b1;
    end
    vectors++;
    if (spurious) begin
      miscompares++;
      $display("FAIL reset_discard: got out_valid/busy after reset, want idle");
    end
    run_a(8'h01, 2'd0, r, o, lat);
    vectors++;
    if ({r, o} !== {8'hFF, 1'b0} || lat !== 8) begin
      miscompares++;
      $display("FAIL reset_next: got %h ovf=%b lat=%0d, want FF ovf=0 lat=8", r, o, lat);
    end
  endtask

  task automatic test_wide();
    logic [15:0] r;
    logic        o;
    int          lat;
    run_b(16'h0001, 2'd0, r, o, lat);
    vectors++;
    if ({r, o} !== {16'hFFFF, 1'b0} || lat !== 8) begin
      miscompares++;
      $display("FAIL wide_neg1: got %h ovf=%b lat=%0d, want FFFF ovf=0 lat=8", r, o, lat);
    end
    run_b(16'h8000, 2'd1, r, o, lat);
    vectors++;
    if ({r, o} !== {16'h8000, 1'b1} || lat !== 8) begin
      miscompares++;
      $display("FAIL wide_absmin: got %h ovf=%b lat=%0d, want 8000 ovf=1 lat=8", r, o, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d, r, er;
    logic [7:0]  ra;
    logic [1:0]  m;
    logic        o, eo;
    int          lat;
    for (int i = 0; i < 40; i++) begin
      d = 16'($urandom);
      case ($urandom_range(0, 5))
        0: d = 16'h0080;
        1: d = 16'h8000;
        2: d = 16'h0000;
        default: ;
      endcase
      m = 2'($urandom);
      model({8'h00, d[7:0]}, m, 8, er, eo);
      run_a(d[7:0], m, ra, o, lat);
      vectors++;
      if ({ra, o} !== {er[7:0], eo} || lat !== 8 || a_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_a[%0d] m%0d %h: got %h ovf=%b lat=%0d ready=%b, want %h ovf=%b lat=8 ready=1",
                 i, m, d[7:0], ra, o, lat, a_in_ready, er[7:0], eo);
      end
      model(d, m, 16, er, eo);
      run_b(d, m, r, o, lat);
      vectors++;
      if ({r, o} !== {er, eo} || lat !== 8 || b_in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_b[%0d] m%0d %h: got %h ovf=%b lat=%0d ready=%b, want %h ovf=%b lat=8 ready=1",
                 i, m, d, r, o, lat, b_in_ready, er, eo);
      end
    end
  endtask

  initial begin
    a_in_valid = 1'b0; a_in_data = '0; a_in_mode = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_data = '0; b_in_mode = '0; b_out_ready = 1'b0;
    test_reset();
    test_directed();
    test_hold();
    test_reset_mid();
    test_wide();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
